// File: rtl/port_tx_fsm.sv
// port_tx_fsm: egress controller that streams FIFO packets out on valid/ready,
// checks packet parity and drops packets whose consumer stalls too long.
//   clk, rst_n        clock, synchronous active-low reset
//   i_fifo_empty      port FIFO has no entry
//   o_fifo_rd_en      pop request, data returns on i_fifo_rdata/i_fifo_rlast next cycle
//   o_tx_valid/data/last, i_tx_ready   egress byte stream, last marks the parity byte
//   o_tx_busy         high from leaving IDLE until GAP completes
//   o_parity_err      pulse: XOR of all packet bytes is nonzero
//   o_drop_pkt        pulse: packet aborted by consumer stall timeout
module port_tx_fsm #(
    parameter int W_WIDTH = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_fifo_empty,
    output logic               o_fifo_rd_en,
    input  logic [W_WIDTH-1:0] i_fifo_rdata,
    input  logic               i_fifo_rlast,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [W_WIDTH-1:0] o_tx_data,
    output logic               o_tx_last,
    output logic               o_tx_busy,
    output logic               o_parity_err,
    output logic               o_drop_pkt
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DRAIN, GAP} state_t;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [W_WIDTH-1:0] r_acc;
    logic               r_pend;
    logic               w_hs;
    logic               w_drain_end;
    logic               w_expire;
    assign w_hs        = o_tx_valid && i_tx_ready;
    // r_pend marks that i_fifo_rdata/i_fifo_rlast carry a freshly popped entry
    assign w_drain_end = r_pend && i_fifo_rlast;
    assign w_expire    = r_cnt == CW'(TIMEOUT - 1);
    // no pops while reset is held; DRAIN stops popping once the tail entry returns
    assign o_fifo_rd_en = rst_n && !i_fifo_empty &&
                          (r_state == IDLE || r_state == FETCH ||
                           (r_state == SEND && w_hs && !o_tx_last) ||
                           (r_state == DRAIN && !w_drain_end));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_pend       <= 1'b0;
            o_tx_valid   <= 1'b0;
            o_tx_data    <= '0;
            o_tx_last    <= 1'b0;
            o_tx_busy    <= 1'b0;
            o_parity_err <= 1'b0;
            o_drop_pkt   <= 1'b0;
        end else begin
            o_parity_err <= 1'b0;
            o_drop_pkt   <= 1'b0;
            r_pend       <= o_fifo_rd_en;
            case (r_state)
                IDLE: if (!i_fifo_empty) begin
                    r_acc     <= '0;
                    o_tx_busy <= 1'b1;
                    r_state   <= LOAD;
                end
                FETCH: if (!i_fifo_empty) r_state <= LOAD;
                LOAD: begin
                    o_tx_data  <= i_fifo_rdata;
                    o_tx_last  <= i_fifo_rlast;
                    o_tx_valid <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (w_hs) begin
                        r_acc      <= r_acc ^ o_tx_data;
                        o_tx_valid <= 1'b0;
                        if (o_tx_last) begin
                            o_parity_err <= |(r_acc ^ o_tx_data);
                            r_state      <= GAP;
                        end else begin
                            r_state <= i_fifo_empty ? FETCH : LOAD;
                        end
                    end else if (w_expire) begin
                        // the tail byte was already fetched, so nothing is left to drain
                        o_tx_valid <= 1'b0;
                        o_drop_pkt <= o_tx_last;
                        r_state    <= o_tx_last ? GAP : DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: if (w_drain_end) begin
                    o_drop_pkt <= 1'b1;
                    r_state    <= GAP;
                end
                GAP: begin
                    o_tx_busy <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_port_tx_fsm.sv
// tb_port_tx_fsm: directed checks of port_tx_fsm against hand-computed timelines.
module tb_port_tx_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rlast = 1'b0;
    logic       tx_ready = 1'b1;
    logic       fifo_rd_en, tx_valid, tx_last, tx_busy, parity_err, drop_pkt;
    logic [7:0] tx_data;

    logic [8:0] q[$];
    logic [8:0] hs[$];
    int         hs_t[$];
    int         cyc_n = 0;
    int         t0, pe_n, pe_t, dp_n, dp_t;
    int         n_cmp = 0;
    int         n_bad = 0;

    port_tx_fsm #(.W_WIDTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_fifo_empty(fifo_empty), .o_fifo_rd_en(fifo_rd_en),
        .i_fifo_rdata(fifo_rdata), .i_fifo_rlast(fifo_rlast),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_tx_data(tx_data), .o_tx_last(tx_last), .o_tx_busy(tx_busy),
        .o_parity_err(parity_err), .o_drop_pkt(drop_pkt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: sample comb/handshake at negedge, model the FIFO pop just after posedge
    task automatic cyc();
        logic rd;
        cyc_n++;
        @(negedge clk);
        rd = fifo_rd_en;
        if (tx_valid && tx_ready) begin
            hs.push_back({tx_last, tx_data});
            hs_t.push_back(cyc_n);
        end
        @(posedge clk);
        #1;
        if (rd && q.size() > 0) {fifo_rlast, fifo_rdata} = q.pop_front();
        fifo_empty = (q.size() == 0);
        if (parity_err) begin pe_n++; pe_t = cyc_n; end
        if (drop_pkt) begin dp_n++; dp_t = cyc_n; end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic push(input logic last, input logic [7:0] d);
        q.push_back({last, d});
        fifo_empty = 1'b0;
    endtask

    task automatic start();
        hs.delete();
        hs_t.delete();
        pe_n = 0; pe_t = -1; dp_n = 0; dp_t = -1;
        t0 = cyc_n;
    endtask

    task automatic chk_hs(input string tag, input int i, input logic [8:0] e, input int t);
        if (i < hs.size()) begin
            chk($sformatf("%s_byte%0d", tag, i), int'(hs[i]), int'(e));
            chk($sformatf("%s_time%0d", tag, i), hs_t[i] - t0, t);
        end else begin
            chk($sformatf("%s_missing%0d", tag, i), hs.size(), i + 1);
        end
    endtask

    initial begin
        // reset state
        run(2);
        chk("rst_valid", int'(tx_valid), 0);
        chk("rst_data", int'(tx_data), 0);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_flags", int'({tx_last, parity_err, drop_pkt, fifo_rd_en}), 0);
        rst_n = 1'b1;
        run(1);
        chk("idle_busy", int'(tx_busy), 0);

        // good packet, full throughput
        start();
        push(0, 8'h03); push(0, 8'hA5); push(0, 8'h5A); push(1, 8'hFC);
        run(9);
        chk("t1_gap_busy", int'(tx_busy), 1);
        chk("t1_gap_valid", int'(tx_valid), 0);
        run(1);
        chk("t1_idle_busy", int'(tx_busy), 0);
        chk_hs("t1", 0, 9'h003, 3);
        chk_hs("t1", 1, 9'h0A5, 5);
        chk_hs("t1", 2, 9'h05A, 7);
        chk_hs("t1", 3, 9'h1FC, 9);
        chk("t1_pe", pe_n, 0);

        // bad parity on last byte
        start();
        push(0, 8'h03); push(0, 8'hA5); push(0, 8'h5A); push(1, 8'h07);
        run(10);
        chk_hs("t2", 3, 9'h107, 9);
        chk("t2_pe_n", pe_n, 1);
        chk("t2_pe_t", pe_t - t0, 9);

        // short stall on byte 2
        start();
        push(0, 8'h03); push(0, 8'hA5); push(0, 8'h5A); push(1, 8'hFC);
        run(4);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t3_hold_data%0d", i), int'(tx_data), 8'hA5);
            chk($sformatf("t3_hold_valid%0d", i), int'(tx_valid), 1);
        end
        tx_ready = 1'b1;
        run(6);
        chk_hs("t3", 1, 9'h0A5, 8);
        chk_hs("t3", 3, 9'h1FC, 12);
        chk("t3_drop", dp_n, 0);
        chk("t3_pe", pe_n, 0);

        // timeout on byte 2 of 6, then next packet
        start();
        push(0, 8'h01); push(0, 8'hA5); push(0, 8'h10); push(0, 8'h20); push(0, 8'h30); push(1, 8'h40);
        push(0, 8'h02); push(1, 8'h02);
        run(4);
        tx_ready = 1'b0;
        run(15);
        chk("t4_valid_pre", int'(tx_valid), 1);
        cyc();
        chk("t4_valid_abort", int'(tx_valid), 0);
        tx_ready = 1'b1;
        run(5);
        chk("t4_dp_n", dp_n, 1);
        chk("t4_dp_t", dp_t - t0, 25);
        chk("t4_fifo_left", q.size(), 2);
        run(6);
        chk_hs("t4", 0, 9'h001, 3);
        chk_hs("t4", 1, 9'h002, 29);
        chk_hs("t4", 2, 9'h102, 31);
        run(1);
        chk("t4_busy", int'(tx_busy), 0);
        chk("t4_pe", pe_n, 0);
        chk("t4_dp_once", dp_n, 1);

        // underrun after byte 2
        start();
        push(0, 8'h01); push(0, 8'hA5);
        run(5);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t5_wait_valid%0d", i), int'(tx_valid), 0);
            chk($sformatf("t5_wait_busy%0d", i), int'(tx_busy), 1);
        end
        push(0, 8'h5A); push(1, 8'hFE);
        run(6);
        chk_hs("t5", 1, 9'h0A5, 5);
        chk_hs("t5", 2, 9'h05A, 13);
        chk_hs("t5", 3, 9'h1FE, 15);
        chk("t5_drop", dp_n, 0);
        chk("t5_pe", pe_n, 0);

        // reset mid-SEND
        start();
        push(0, 8'h11); push(0, 8'h22); push(1, 8'h33);
        run(2);
        tx_ready = 1'b0;
        run(1);
        rst_n = 1'b0;
        cyc();
        chk("t6_valid", int'(tx_valid), 0);
        chk("t6_data", int'(tx_data), 0);
        chk("t6_busy", int'(tx_busy), 0);
        chk("t6_flags", int'({tx_last, parity_err, drop_pkt, fifo_rd_en}), 0);
        chk("t6_fifo", q.size(), 2);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        run(6);
        chk_hs("t6", 0, 9'h022, 7);
        chk_hs("t6", 1, 9'h133, 9);
        chk("t6_pe_t", pe_t - t0, 9);

        // single-byte packets
        start();
        push(1, 8'h00); push(1, 8'h5C);
        run(8);
        chk_hs("t7", 0, 9'h100, 3);
        chk_hs("t7", 1, 9'h15C, 7);
        chk("t7_pe_n", pe_n, 1);
        chk("t7_pe_t", pe_t - t0, 7);

        // ready returns exactly on the expiry cycle
        start();
        push(0, 8'h03); push(0, 8'hA5); push(0, 8'h5A); push(1, 8'hFC);
        run(4);
        tx_ready = 1'b0;
        run(15);
        tx_ready = 1'b1;
        run(6);
        chk_hs("t8", 1, 9'h0A5, 20);
        chk_hs("t8", 3, 9'h1FC, 24);
        chk("t8_drop", dp_n, 0);

        // timeout on a tail byte goes straight to GAP
        start();
        push(1, 8'h77);
        run(2);
        tx_ready = 1'b0;
        run(16);
        chk("t9_dp_n", dp_n, 1);
        chk("t9_dp_t", dp_t - t0, 18);
        chk("t9_valid", int'(tx_valid), 0);
        tx_ready = 1'b1;
        run(1);
        chk("t9_busy", int'(tx_busy), 0);
        chk("t9_hs", hs.size(), 0);
        chk("t9_pe", pe_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
